// File: rtl/a2d_conv_sched_if.sv
// SPI transaction handshake between the conversion scheduler (master) and the SPI engine (slave).
interface a2d_conv_sched_if;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;

   modport master (output wrt, output cmd, input done, input rd_data);
   modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/a2d_conv_sched.sv
// Round-robin A2D conversion scheduler: one two-transaction SPI conversion per periodic trigger,
// cycling battery, current, brake and torque channels.
module a2d_conv_sched #(
   parameter bit FastSim = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   a2d_conv_sched_if.master spi,
   output logic [11:0]      batt_o,
   output logic [11:0]      curr_o,
   output logic [11:0]      brake_o,
   output logic [11:0]      torque_o,
   output logic             conv_cmplt_o
);

   typedef enum logic [1:0] {StIdle, StWait1, StPause, StWait2} state_e;

   state_e      state_q, state_d;
   logic [13:0] cnt_q;
   logic [1:0]  rr_idx_q, rr_idx_d;
   logic        wrt_q, wrt_d;
   logic [15:0] cmd_q, cmd_d;
   logic [11:0] batt_q, batt_d;
   logic [11:0] curr_q, curr_d;
   logic [11:0] brake_q, brake_d;
   logic [11:0] torque_q, torque_d;
   logic        cmplt_q, cmplt_d;
   logic        trig;
   logic [2:0]  chnl;
   logic        unused_rd_hi;

   assign trig = FastSim ? (&cnt_q[9:0]) : (&cnt_q);

   // Converter channel numbers are not contiguous: ch2 is skipped.
   always_comb begin
      chnl = 3'd0;
      unique case (rr_idx_q)
         2'd0: chnl = 3'd0;
         2'd1: chnl = 3'd1;
         2'd2: chnl = 3'd3;
         2'd3: chnl = 3'd4;
         default: chnl = 3'd0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         rr_idx_q <= '0;
         wrt_q    <= 1'b0;
         cmd_q    <= '0;
         batt_q   <= '0;
         curr_q   <= '0;
         brake_q  <= '0;
         torque_q <= '0;
         cmplt_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_q + 14'd1;
         rr_idx_q <= rr_idx_d;
         wrt_q    <= wrt_d;
         cmd_q    <= cmd_d;
         batt_q   <= batt_d;
         curr_q   <= curr_d;
         brake_q  <= brake_d;
         torque_q <= torque_d;
         cmplt_q  <= cmplt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (trig) state_d = StWait1;
         StWait1: if (spi.done) state_d = StPause;
         StPause: state_d = StWait2;
         StWait2: if (spi.done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wrt_d    = 1'b0;
      cmd_d    = cmd_q;
      rr_idx_d = rr_idx_q;
      batt_d   = batt_q;
      curr_d   = curr_q;
      brake_d  = brake_q;
      torque_d = torque_q;
      cmplt_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (trig) begin
               cmd_d = {2'b00, chnl, 11'h000};
               wrt_d = 1'b1;
            end
         end
         StPause: wrt_d = 1'b1;
         StWait2: begin
            if (spi.done) begin
               cmplt_d  = 1'b1;
               rr_idx_d = rr_idx_q + 2'd1;
               unique case (rr_idx_q)
                  2'd0: batt_d   = spi.rd_data[11:0];
                  2'd1: curr_d   = spi.rd_data[11:0];
                  2'd2: brake_d  = spi.rd_data[11:0];
                  2'd3: torque_d = spi.rd_data[11:0];
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   assign spi.wrt      = wrt_q;
   assign spi.cmd      = cmd_q;
   assign batt_o       = batt_q;
   assign curr_o       = curr_q;
   assign brake_o      = brake_q;
   assign torque_o     = torque_q;
   assign conv_cmplt_o = cmplt_q;
   assign unused_rd_hi = ^spi.rd_data[15:12];

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Self-checking bench for a2d_conv_sched: scripted SPI responder plus a result scoreboard.
module tb_a2d_conv_sched;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] batt, curr, brake, torque;
   logic        conv_cmplt;

   a2d_conv_sched_if spi ();

   a2d_conv_sched #(
      .FastSim(1'b1)
   ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .spi         (spi),
      .batt_o      (batt),
      .curr_o      (curr),
      .brake_o     (brake),
      .torque_o    (torque),
      .conv_cmplt_o(conv_cmplt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [11:0] val;
   } exp_t;

   exp_t        sb_q[$];
   logic [11:0] exp_reg [4];
   logic [15:0] cmd_tab [4];
   int          rr_exp = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cmplt_cnt = 0;
   logic        wrt_prev = 1'b0;
   logic        cmplt_prev = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check_eq({tag, "_batt"}, 32'(batt), 32'(exp_reg[0]));
      check_eq({tag, "_curr"}, 32'(curr), 32'(exp_reg[1]));
      check_eq({tag, "_brake"}, 32'(brake), 32'(exp_reg[2]));
      check_eq({tag, "_torque"}, 32'(torque), 32'(exp_reg[3]));
   endtask

   task automatic model_clear();
      foreach (exp_reg[i]) exp_reg[i] = 12'h000;
      rr_exp = 0;
   endtask

   // Scoreboard side: every completion must match the oldest pushed expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (wrt_prev) check_eq("wrt_width", 32'(spi.wrt), 32'd0);
      if (cmplt_prev) check_eq("cmplt_width", 32'(conv_cmplt), 32'd0);
      if (conv_cmplt) begin
         cmplt_cnt++;
         if (sb_q.size() == 0) begin
            check_eq("cmplt_unexpected", 32'(conv_cmplt), 32'd0);
         end else begin
            e = sb_q.pop_front();
            exp_reg[e.idx] = e.val;
            check_regs("capture");
         end
      end
      wrt_prev   = spi.wrt;
      cmplt_prev = conv_cmplt;
   end

   task automatic wait_wrt(output bit ok);
      ok = spi.wrt;
      for (int i = 0; i < 2100 && !ok; i++) begin
         @(negedge clk);
         ok = spi.wrt;
      end
      if (!ok) check_eq("wrt_timeout", 32'd0, 32'd1);
   endtask

   task automatic gap(input int n, input string tag);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (spi.wrt) seen++;
      end
      check_eq(tag, seen, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      check_regs("rst");
      check_eq("rst_cmplt", 32'(conv_cmplt), 32'd0);
      check_eq("rst_cmd", 32'(spi.cmd), 32'd0);
   endtask

   // One full conversion; SPI done returned d1/d2 cycles after each wrt.
   task automatic conv(input logic [15:0] data, input int d1, input int d2,
                       input bit spur_pause, input bit rst_mid);
      bit ok;
      wait_wrt(ok);
      if (!ok) return;
      check_eq("cmd1", 32'(spi.cmd), 32'(cmd_tab[rr_exp]));
      gap(d1, "wrt_in_wait1");
      spi.done    = 1'b1;
      spi.rd_data = 16'($urandom);
      @(negedge clk);
      spi.done = spur_pause;
      spi.rd_data = 16'h0FFF;
      check_eq("pause_no_wrt", 32'(spi.wrt), 32'd0);
      @(negedge clk);
      spi.done = 1'b0;
      check_eq("wrt2_after_pause", 32'(spi.wrt), 32'd1);
      check_eq("cmd2", 32'(spi.cmd), 32'(cmd_tab[rr_exp]));
      if (rst_mid) begin
         gap(d2 - 1, "wrt_in_wait2");
         rst_n = 1'b0;
         @(negedge clk);
         rst_n       = 1'b1;
         spi.done    = 1'b1;
         spi.rd_data = data;
         @(negedge clk);
         spi.done = 1'b0;
         model_clear();
         check_eq("late_done_cmplt", 32'(conv_cmplt), 32'd0);
         check_regs("late_done");
      end else begin
         gap(d2, "wrt_in_wait2");
         sb_q.push_back('{idx: rr_exp, val: data[11:0]});
         spi.done    = 1'b1;
         spi.rd_data = data;
         @(negedge clk);
         spi.done = 1'b0;
         check_eq("cmplt_pulse", 32'(conv_cmplt), 32'd1);
         @(negedge clk);
         check_eq("cmplt_low", 32'(conv_cmplt), 32'd0);
         rr_exp = (rr_exp + 1) % 4;
      end
   endtask

   initial begin
      int cyc;
      int c0;
      cmd_tab     = '{16'h0000, 16'h0800, 16'h1800, 16'h2000};
      spi.done    = 1'b0;
      spi.rd_data = 16'h0000;
      rst_n       = 1'b0;
      model_clear();

      // Reset with done toggling: nothing may start.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         spi.done = ~spi.done;
         check_eq("rst_no_wrt", 32'(spi.wrt), 32'd0);
      end
      @(negedge clk);
      spi.done = 1'b0;
      check_regs("reset");
      check_eq("reset_cmd", 32'(spi.cmd), 32'd0);
      check_eq("reset_cmplt", 32'(conv_cmplt), 32'd0);
      rst_n = 1'b1;
      cyc   = 1;
      while (!spi.wrt && cyc < 1200) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("first_wrt_cycle", cyc, 1025);

      // Single conversion on ch0.
      conv(16'hFABC, 20, 20, 1'b0, 1'b0);
      check_regs("single");

      // Round robin over all four channels, then wrap back to ch0.
      do_reset();
      conv(16'h0111, 20, 20, 1'b0, 1'b0);
      conv(16'h0222, 20, 20, 1'b0, 1'b0);
      conv(16'h0333, 20, 20, 1'b0, 1'b0);
      conv(16'h0444, 20, 20, 1'b0, 1'b0);
      check_regs("rr");
      conv(16'h0AAA, 20, 20, 1'b0, 1'b0);

      // Spurious done in IDLE, then in PAUSE.
      gap(5, "idle_no_wrt");
      spi.done    = 1'b1;
      spi.rd_data = 16'hF777;
      @(negedge clk);
      spi.done = 1'b0;
      @(negedge clk);
      check_eq("idle_done_cmplt", 32'(conv_cmplt), 32'd0);
      check_regs("idle_done");
      conv(16'h0BBB, 20, 20, 1'b1, 1'b0);

      // Trigger lands in WAIT1 and must be dropped.
      c0 = cmplt_cnt;
      conv(16'h0CCC, 1100, 20, 1'b0, 1'b0);
      check_eq("dropped_cmplt_cnt", cmplt_cnt - c0, 1);
      conv(16'h0DDD, 20, 20, 1'b0, 1'b0);

      // Reset one cycle before the second done; restart at ch0.
      conv(16'h0E01, 20, 20, 1'b0, 1'b1);
      gap(50, "post_rst_idle");
      conv(16'h0E02, 20, 20, 1'b0, 1'b0);
      check_regs("final");
      check_eq("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/a2d_conv_sched.md
Name: a2d_conv_sched

Overview:
- Round-robin scheduler that sequences the shared SPI A2D converter and feeds raw 12-bit samples to sensor conditioning.
- Samples four channels in order: battery (ch0), current (ch1), brake (ch3), torque (ch4).
- Runs one conversion per periodic trigger. Each conversion takes two SPI transactions: the first sends the channel command, the second reads back the result.
- Sits between the SPI master and the sensor-conditioning/brake logic.

Parameters:
- FAST_SIM, 1'b1: 1 gives a trigger period of 2^10 clocks; 0 gives 2^14 clocks.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- wrt  output  1  one-cycle pulse that starts an SPI transaction.
- cmd  output  16  SPI command word.
- done  input  1  one-cycle pulse from the SPI master when a transaction completes.
- rd_data  input  16  SPI read data; valid in the cycle done is high.
- batt  output  12  latest ch0 result.
- curr  output  12  latest ch1 result.
- brake  output  12  latest ch3 result.
- torque  output  12  latest ch4 result.
- conv_cmplt  output  1  one-cycle pulse when a result register updates.

Behaviour:
- All state is updated on posedge clk. rst_n is sampled synchronously; when low, every register is cleared next edge.
- Reset values: wrt=0, cmd=0, batt=curr=brake=torque=0, conv_cmplt=0, period counter=0, rr_idx=0, state=IDLE.
- Period counter:
  - Free-running 14-bit counter; wraps naturally.
  - trig = &cnt[9:0] when FAST_SIM, else &cnt[13:0].
  - The first trig occurs on the 1024th (or 16384th) cycle after reset release.
- rr_idx: 2-bit round-robin index. Channel map is 0->ch0, 1->ch1, 2->ch3, 3->ch4.
- cmd = {2'b00, chnl[2:0], 11'h000}. It is held stable from the first wrt through the end of the conversion.
- State machine (wrt is registered; a state's wrt pulse is issued one cycle after the transition that enters that state):
  - IDLE: on trig, load cmd for rr_idx and assert wrt next cycle -> WAIT1.
  - WAIT1: wait for done -> PAUSE.
  - PAUSE: exactly one cycle, then assert wrt (same cmd) -> WAIT2.
  - WAIT2: on done, capture rd_data[11:0] into the register selected by rr_idx on the next edge. In that same cycle pulse conv_cmplt, increment rr_idx (3 wraps to 0), and go -> IDLE.
- wrt is high for exactly one cycle per transaction. It is never asserted while a transaction is outstanding.
- rd_data[15:12] is ignored.
- done is ignored in IDLE and PAUSE.
- A trig arriving in any state other than IDLE is dropped, not queued.
- Only the selected channel register changes on capture; the others hold.
- A reset mid-transaction returns to IDLE with all outputs cleared. A late done after reset is ignored.
- Latency, trig to first wrt: 1 cycle. Second done to result visible: 1 cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with done toggling -> all outputs 0, no wrt pulse; wrt first rises exactly 1025 cycles after release (FAST_SIM=1).
- Single conversion: first trig; SPI model returns done 20 cycles after each wrt with rd_data=16'hFABC -> cmd=16'h0000, two wrt pulses with one PAUSE cycle between done and the second wrt, batt=12'hABC, conv_cmplt high for one cycle, other registers 0.
- Round robin: four trigs with rd_data 16'h0111/16'h0222/16'h0333/16'h0444 -> cmd sequence 16'h0000, 16'h0800, 16'h1800, 16'h2000; batt=111, curr=222, brake=333, torque=444 (hex); fifth trig issues 16'h0000 again.
- Dropped trigger: SPI model delays done 1100 cycles in WAIT1 so a second trig lands mid-conversion -> no extra wrt, exactly one conv_cmplt, rr_idx advances by one only.
- Spurious done: pulse done while in IDLE and during PAUSE -> no state change, no capture, no conv_cmplt.
- Reset mid-WAIT2: assert rst_n=0 one cycle before the second done -> the targeted register stays 0, state returns to IDLE, the next trig restarts at ch0 with cmd=16'h0000.
